// File: rtl/dot_round_ctrl.sv
// Fixed-point dot-product lane sequencer: accumulates VEC_LEN exact products,
// then rounds half-up and saturates back to Q(INT_BITS).(FRAC_BITS).
module dot_round_ctrl #(
  parameter int INT_BITS   = 7,
  parameter int FRAC_BITS  = 9,
  parameter int VEC_LEN    = 4,
  parameter int GUARD_BITS = 4,
  localparam int W         = INT_BITS + FRAC_BITS,
  localparam int ACC_W     = 2 * W + GUARD_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_sat,
  output logic         busy,
  output logic [15:0]  sat_count
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int RW    = ACC_W - FRAC_BITS + 1;

  localparam logic signed [RW-1:0] MAX_R = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_R = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]         MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         MIN_W = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state, state_next;

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        beat_cnt;
  logic signed [2*W-1:0]   prod;
  logic signed [RW-1:0]    r;
  logic                    last_beat;
  logic                    sat_hi, sat_lo;
  logic [W-1:0]            r_sat;
  logic                    unused_frac;

  assign prod      = $signed(in_a) * $signed(in_b);
  assign last_beat = (beat_cnt == CNT_W'(VEC_LEN - 1));

  // Floor-shift plus the half bit gives round-half-up; one extra MSB keeps the
  // +1 from wrapping at the most positive accumulator value.
  assign r = $signed({acc[ACC_W-1], acc[ACC_W-1:FRAC_BITS]})
           + $signed({{(RW-1){1'b0}}, acc[FRAC_BITS-1]});

  assign sat_hi      = (r > MAX_R);
  assign sat_lo      = (r < MIN_R);
  assign r_sat       = sat_hi ? MAX_W : (sat_lo ? MIN_W : r[W-1:0]);
  assign unused_frac = ^acc[FRAC_BITS-1:0];

  // Handshake outputs decode the state register only, so neither in_valid nor
  // out_ready can reach them combinationally.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next-state is assigned a default before the case so no path through
  // this block can hold its old value and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACC;
      ACC:     if (in_valid && last_beat) state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      beat_cnt  <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      sat_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            beat_cnt <= '0;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc      <= acc + ACC_W'(prod);
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        ROUND: begin
          out_data <= r_sat;
          out_sat  <= sat_hi | sat_lo;
          if ((sat_hi | sat_lo) && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_round_ctrl.sv
// Scoreboard bench for dot_round_ctrl: a behavioural model queues expected
// results at issue time; an independent monitor checks them on each handshake.
module tb_dot_round_ctrl;

  localparam int W    = 16;
  localparam int FRAC = 9;
  localparam int VL   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sat;
  logic          busy;
  logic [15:0]   sat_count;

  typedef struct packed {
    logic [W-1:0] data;
    logic         sat;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] va[VL];
  logic [W-1:0] vb[VL];
  int           gap_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [15:0]  sc_model;
  int           checks   = 0;
  int           failures = 0;

  dot_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Exact dot product, then floor((sum + half) / 2^FRAC), then clamp.
  function automatic exp_t model();
    exp_t   e;
    longint s = 0;
    longint r;
    for (int i = 0; i < VL; i++)
      s += longint'($signed(va[i])) * longint'($signed(vb[i]));
    r = (s + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    if (r > 32767) begin
      e.data = 16'h7FFF; e.sat = 1'b1;
    end else if (r < -32768) begin
      e.data = 16'h8000; e.sat = 1'b1;
    end else begin
      e.data = r[15:0];  e.sat = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", {16'h0, out_data}, {16'h0, e.data});
        check("out_sat", {31'h0, out_sat}, {31'h0, e.sat});
      end
    end
  end

  task automatic set_all(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < VL; i++) begin
      va[i] = a;
      vb[i] = b;
    end
  endtask

  // gap_mode: 0 = no gaps, 1 = random gaps, 2 = fixed toggle pattern.
  task automatic run_vec(input int gap_mode, input bit bp);
    exp_t e;
    int   i, cyc, k;
    bit   v;
    e = model();
    sb.push_back(e);
    if (e.sat && sc_model != 16'hFFFF) sc_model++;
    out_ready = !bp;

    @(negedge clk);
    check("idle_before_start", {31'h0, busy}, 32'h0);
    start = 1'b1;
    i = 0; cyc = 0; k = 0;
    while (i < VL && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) check("in_ready_first", {31'h0, in_ready}, 32'h1);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = (k < 7) ? (gap_pat[k] != 0) : 1'b1;
      endcase
      k++;
      in_valid = v;
      in_a     = va[i];
      in_b     = vb[i];
      if (v && in_ready) i++;
      cyc++;
    end
    if (i < VL) check("beat_budget", 32'(i), 32'(VL));

    // ROUND cycle: keep offering a beat that must not be counted.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'h0200;
    in_b     = 16'h0200;
    check("round_in_ready", {31'h0, in_ready}, 32'h0);
    check("round_out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_out_valid", {31'h0, out_valid}, 32'h1);

    if (bp) begin
      for (int c = 0; c < 5; c++) begin
        start    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_out_valid", {31'h0, out_valid}, 32'h1);
        check("bp_out_data", {16'h0, out_data}, {16'h0, e.data});
        check("bp_out_sat", {31'h0, out_sat}, {31'h0, e.sat});
        check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_busy_after_hs", {31'h0, busy}, 32'h0);
      start    = 1'b0;
      in_valid = 1'b0;
    end

    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("return_idle", {31'h0, busy}, 32'h0);
    check("sat_count", {16'h0, sat_count}, {16'h0, sc_model});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_out_data"}, {16'h0, out_data}, 32'h0);
    check({tag, "_out_sat"}, {31'h0, out_sat}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_sat_count"}, {16'h0, sat_count}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; sc_model = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    set_all(16'h0200, 16'h0200);
    run_vec(0, 1'b0);

    va = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    vb = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
    run_vec(0, 1'b0);
    vb[0] = 16'h00FF;
    run_vec(0, 1'b0);
    va[0] = 16'hFFFF; vb[0] = 16'h0100;
    run_vec(0, 1'b0);
    vb[0] = 16'h0101;
    run_vec(0, 1'b0);

    set_all(16'h7FFF, 16'h7FFF);
    run_vec(0, 1'b0);
    set_all(16'h8000, 16'h7FFF);
    run_vec(0, 1'b0);
    check("sat_count_two", {16'h0, sat_count}, 32'h2);

    set_all(16'h0200, 16'h0200);
    run_vec(0, 1'b1);
    run_vec(2, 1'b0);

    // Abort mid-accumulation with an asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = 16'h0200; in_b = 16'h0200;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sc_model = '0;
    set_all(16'h0200, 16'h0200);
    run_vec(0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < VL; i++) begin
        if ($urandom_range(0, 1) != 0) begin
          va[i] = 16'($urandom);
          vb[i] = 16'($urandom);
        end else begin
          va[i] = 16'($urandom_range(0, 4095) - 2048);
          vb[i] = 16'($urandom_range(0, 4095) - 2048);
        end
      end
      run_vec(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
